// File: rtl/tdc_readout_if.sv
// tdc_readout_if: TDC channel array plus downstream valid/ready event bus
interface tdc_readout_if #(
    parameter int NUM_CHAN = 4,
    parameter int TS_W = 32,
    parameter int TOT_W = 32
);
    localparam int CHAN_W = $clog2(NUM_CHAN);
    logic [NUM_CHAN-1:0]       chan_has_event;
    logic [NUM_CHAN*TS_W-1:0]  chan_timestamp;
    logic [NUM_CHAN*TOT_W-1:0] chan_tot;
    logic [NUM_CHAN-1:0]       chan_clear;
    logic                      out_valid;
    logic                      out_ready;
    logic [CHAN_W-1:0]         out_chan;
    logic [TS_W-1:0]           out_timestamp;
    logic [TOT_W-1:0]          out_tot;
    modport master (
        input  chan_has_event, chan_timestamp, chan_tot, out_ready,
        output chan_clear, out_valid, out_chan, out_timestamp, out_tot
    );
    modport slave (
        output chan_has_event, chan_timestamp, chan_tot, out_ready,
        input  chan_clear, out_valid, out_chan, out_timestamp, out_tot
    );
endinterface

// File: rtl/tdc_readout_arbiter.sv
// tdc_readout_arbiter: round-robin TDC channel readout onto a valid/ready bus with per-channel clear
module tdc_readout_arbiter #(
    parameter int NUM_CHAN = 4,
    parameter int TS_W = 32,
    parameter int TOT_W = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              flush,
    tdc_readout_if.master     bus,
    output logic              busy,
    output logic [CNT_W-1:0]  event_count
);
    localparam int CHAN_W = $clog2(NUM_CHAN);
    typedef enum logic [1:0] {IDLE, PRESENT, CLEAR} state_t;
    state_t               state, state_nx;
    logic [CHAN_W-1:0]    rr_ptr, rr_ptr_nx, sel, chan_nx;
    logic [NUM_CHAN-1:0]  rot, clear_nx;
    logic                 found, valid_nx;
    logic [TS_W-1:0]      sel_ts, ts_nx;
    logic [TOT_W-1:0]     sel_tot, tot_nx;
    logic [CNT_W-1:0]     count_nx;
    // Rotating the request vector by rr_ptr turns round-robin into a plain lowest-index search.
    assign rot = NUM_CHAN'({bus.chan_has_event, bus.chan_has_event} >> rr_ptr);
    assign busy = state != IDLE;
    always_comb begin
        found = 1'b0;
        sel = rr_ptr;
        for (int k = NUM_CHAN - 1; k >= 0; k--)
            if (rot[k]) begin
                found = 1'b1;
                sel = CHAN_W'((int'(rr_ptr) + k) % NUM_CHAN);
            end
        sel_ts = '0;
        sel_tot = '0;
        for (int i = 0; i < NUM_CHAN; i++)
            if (sel == CHAN_W'(i)) begin
                sel_ts = bus.chan_timestamp[i*TS_W +: TS_W];
                sel_tot = bus.chan_tot[i*TOT_W +: TOT_W];
            end
    end
    always_comb begin
        state_nx = state;
        rr_ptr_nx = rr_ptr;
        valid_nx = bus.out_valid;
        chan_nx = bus.out_chan;
        ts_nx = bus.out_timestamp;
        tot_nx = bus.out_tot;
        clear_nx = '0;
        count_nx = event_count;
        if (flush) begin
            valid_nx = 1'b0;
            clear_nx = '1;
            state_nx = CLEAR;
        end else if (state == IDLE) begin
            if (enable && found) begin
                state_nx = PRESENT;
                valid_nx = 1'b1;
                chan_nx = sel;
                ts_nx = sel_ts;
                tot_nx = sel_tot;
            end
        end else if (state == PRESENT) begin
            if (bus.out_valid && bus.out_ready) begin
                state_nx = CLEAR;
                valid_nx = 1'b0;
                clear_nx = NUM_CHAN'(1) << bus.out_chan;
                rr_ptr_nx = (int'(bus.out_chan) == NUM_CHAN - 1) ? '0 : bus.out_chan + 1'b1;
                count_nx = event_count + CNT_W'(event_count != '1);
            end
        end else begin
            state_nx = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            rr_ptr <= '0;
            bus.out_valid <= 1'b0;
            bus.out_chan <= '0;
            bus.out_timestamp <= '0;
            bus.out_tot <= '0;
            bus.chan_clear <= '1;
            event_count <= '0;
        end else begin
            state <= state_nx;
            rr_ptr <= rr_ptr_nx;
            bus.out_valid <= valid_nx;
            bus.out_chan <= chan_nx;
            bus.out_timestamp <= ts_nx;
            bus.out_tot <= tot_nx;
            bus.chan_clear <= clear_nx;
            event_count <= count_nx;
        end
    end
endmodule

// File: tb/tb_tdc_readout_arbiter.sv
// tb_tdc_readout_arbiter: transaction-level reference model plus TDC channel models driving the arbiter
module tb_tdc_readout_arbiter;
    localparam int N = 4;
    logic clk = 1'b0, reset_n = 1'b0, enable = 1'b0, flush = 1'b0;
    logic busy, sat_busy;
    logic [15:0] event_count;
    logic [3:0] sat_count;
    tdc_readout_if #(.NUM_CHAN(N)) bus ();
    tdc_readout_if #(.NUM_CHAN(N)) sat_bus ();
    tdc_readout_arbiter #(.NUM_CHAN(N)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush),
        .bus(bus), .busy(busy), .event_count(event_count)
    );
    tdc_readout_arbiter #(.NUM_CHAN(N), .CNT_W(4)) sat_dut (
        .clk(clk), .reset_n(reset_n), .enable(1'b1), .flush(1'b0),
        .bus(sat_bus), .busy(sat_busy), .event_count(sat_count)
    );
    always #5 clk = ~clk;
    int errors = 0, checks = 0;
    logic [N-1:0] has = '0, prev_clear = '0, rearm = '0;
    bit auto_rearm = 0;
    logic [31:0] ts [N];
    logic [31:0] tot [N];
    bit m_hold = 0;
    int m_cool = 0, m_ptr = 0, m_chan = 0, m_count = 0;
    logic [31:0] m_ts = '0, m_tot = '0;
    logic [N-1:0] m_clear = '0;
    int sat_acc = 0;
    bit sat_prev_valid = 0, prev_valid = 0;
    int prev_chan = 0;
    int acc_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        bus.chan_has_event = has;
        for (int i = 0; i < N; i++) begin
            bus.chan_timestamp[i*32 +: 32] = ts[i];
            bus.chan_tot[i*32 +: 32] = tot[i];
        end
    endtask

    task automatic tick();
        logic [N-1:0] s_has;
        logic [31:0] s_ts [N];
        logic [31:0] s_tot [N];
        bit s_rst, s_en, s_fl, s_rdy;
        drive();
        s_has = has; s_ts = ts; s_tot = tot;
        s_rst = reset_n; s_en = enable; s_fl = flush; s_rdy = bus.out_ready;
        @(posedge clk);
        #1;
        m_clear = '0;
        if (!s_rst) begin
            m_hold = 0; m_cool = 0; m_ptr = 0; m_count = 0; m_clear = '1;
        end else if (s_fl) begin
            m_hold = 0; m_cool = 1; m_clear = '1;
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (m_hold) begin
            if (s_rdy) begin
                m_hold = 0; m_cool = 1; m_clear[m_chan] = 1'b1;
                m_ptr = (m_chan + 1) % N;
                if (m_count < 65535) m_count++;
            end
        end else if (s_en && s_has != '0) begin
            for (int k = 0; k < N; k++)
                if (s_has[(m_ptr + k) % N]) begin
                    m_chan = (m_ptr + k) % N;
                    break;
                end
            m_hold = 1; m_ts = s_ts[m_chan]; m_tot = s_tot[m_chan];
        end
        if (s_rst && !s_fl && prev_valid && s_rdy) acc_q.push_back(prev_chan);
        prev_valid = bus.out_valid;
        prev_chan = int'(bus.out_chan);
        check("valid", bus.out_valid, m_hold);
        check("clear", bus.chan_clear, m_clear);
        check("count", event_count, m_count);
        check("busy", busy, m_hold || m_cool > 0);
        if (m_hold) begin
            check("chan", bus.out_chan, m_chan);
            check("ts", bus.out_timestamp, m_ts);
            check("tot", bus.out_tot, m_tot);
        end
        if (!s_rst) begin
            check("rst_chan", bus.out_chan, 0);
            check("rst_ts", bus.out_timestamp, 0);
            check("rst_tot", bus.out_tot, 0);
        end
        if (!s_rst) sat_acc = 0;
        else if (sat_prev_valid) sat_acc++;
        sat_prev_valid = sat_bus.out_valid;
        check("sat_count", sat_count, sat_acc > 15 ? 15 : sat_acc);
        // TDC models: re-arm one cycle after a drop, drop on an observed clear
        for (int i = 0; i < N; i++)
            if (rearm[i]) begin
                has[i] = 1'b1; ts[i] = $urandom; tot[i] = $urandom;
            end
        rearm = '0;
        for (int i = 0; i < N; i++)
            if (prev_clear[i]) begin
                has[i] = 1'b0;
                if (auto_rearm) rearm[i] = 1'b1;
            end
        prev_clear = bus.chan_clear;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            ts[i] = '0; tot[i] = '0;
        end
        bus.out_ready = 1'b0;
        sat_bus.chan_has_event = 4'b0001;
        sat_bus.chan_timestamp = '0;
        sat_bus.chan_tot = '0;
        sat_bus.out_ready = 1'b1;
        do_reset();
        enable = 1'b1;
        bus.out_ready = 1'b1;
        has[2] = 1'b1; ts[2] = 25505; tot[2] = 199099;
        tick();
        check("single_valid", bus.out_valid, 1);
        check("single_chan", bus.out_chan, 2);
        check("single_ts", bus.out_timestamp, 25505);
        check("single_tot", bus.out_tot, 199099);
        tick();
        check("single_clear", bus.chan_clear, 4'b0100);
        check("single_count", event_count, 1);
        repeat (3) tick();
        do_reset();
        acc_q.delete();
        auto_rearm = 1;
        has = '1;
        repeat (18) tick();
        check("rr_count", event_count, 6);
        check("rr_len", acc_q.size(), 6);
        for (int j = 0; j < 6 && j < acc_q.size(); j++) check("rr_order", acc_q[j], j % 4);
        auto_rearm = 0;
        repeat (16) tick();
        bus.out_ready = 1'b0;
        has[1] = 1'b1; ts[1] = 100; tot[1] = 7;
        tick();
        ts[1] = 555;
        repeat (10) tick();
        check("bp_ts", bus.out_timestamp, 100);
        check("bp_valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        tick();
        check("bp_clear", bus.chan_clear, 4'b0010);
        repeat (2) tick();
        enable = 1'b0;
        bus.out_ready = 1'b0;
        has[3] = 1'b1; ts[3] = $urandom; tot[3] = $urandom;
        repeat (4) tick();
        check("dis_busy", busy, 0);
        check("dis_valid", bus.out_valid, 0);
        enable = 1'b1;
        repeat (2) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_valid", bus.out_valid, 0);
        check("flush_clear", bus.chan_clear, 4'b1111);
        tick();
        check("flush_clear_end", bus.chan_clear, 4'b0000);
        repeat (3) tick();
        has[1] = 1'b1;
        repeat (2) tick();
        do_reset();
        check("rst_rel_clear", bus.chan_clear, 4'b0000);
        has[0] = 1'b1; has[1] = 1'b1;
        tick();
        check("rst_ptr_chan", bus.out_chan, 0);
        bus.out_ready = 1'b1;
        repeat (6) tick();
        for (int c = 0; c < 400; c++) begin
            bus.out_ready = $urandom_range(3) != 0;
            enable = $urandom_range(7) != 0;
            flush = $urandom_range(49) == 0;
            for (int i = 0; i < N; i++)
                if (!has[i] && $urandom_range(3) == 0) begin
                    has[i] = 1'b1; ts[i] = $urandom; tot[i] = $urandom;
                end
            tick();
        end
        flush = 1'b0;
        check("sat_final", sat_count, 15);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tdc_readout_arbiter.md
Name: tdc_readout_arbiter

Overview:
- Round-robin readout scheduler for NUM_CHAN TDC channels.
- Each TDC channel presents hasEvent, timestamp and timeOverThreshold, and holds them until cleared.
- The arbiter selects one pending channel, latches its event and presents it downstream on a valid/ready handshake. It then pulses that channel's clear to re-arm it.
- Sits between the TDC channel array and the event FIFO / serializer.

Parameters:
- NUM_CHAN, 4, number of TDC channels arbitrated (2..16).
- TS_W, 32, timestamp width.
- TOT_W, 32, time-over-threshold width.
- CHAN_W, $clog2(NUM_CHAN), channel index width (derived, not overridden).
- CNT_W, 16, width of the accepted-event counter.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- reset_n  in  1  synchronous active-low reset.
- enable  in  1  arbitration enable; when low, no new grants.
- flush  in  1  one-cycle request to clear all channels and drop any held event.
- chan_hasEvent  in  NUM_CHAN  per-channel event-pending flag.
- chan_timestamp  in  NUM_CHAN*TS_W  packed timestamps; channel i at [i*TS_W +: TS_W].
- chan_tot  in  NUM_CHAN*TOT_W  packed TOT values, same packing.
- chan_clear  out  NUM_CHAN  per-channel clear, active high, registered.
- out_valid  out  1  event available downstream.
- out_ready  in  1  downstream accepts.
- out_chan  out  CHAN_W  channel index of the presented event.
- out_timestamp  out  TS_W  latched timestamp.
- out_tot  out  TOT_W  latched TOT.
- busy  out  1  high in any state other than IDLE.
- event_count  out  CNT_W  accepted events, saturating.

Behaviour:
- Reset (reset_n low at a clk edge):
  - state=IDLE, rr_ptr=0.
  - out_valid=0; out_chan, out_timestamp, out_tot = 0.
  - event_count=0, busy=0.
  - chan_clear = all ones, so every TDC is cleared while reset is held.
  - First cycle after release: chan_clear=0.
- All outputs are registered; no combinational input-to-output paths.
- FSM states: IDLE, PRESENT, CLEAR.
- IDLE:
  - If enable=1 and any chan_hasEvent bit is set: select the first set bit at or after rr_ptr, searching upward with wrap from NUM_CHAN-1 to 0.
  - Latch that channel's timestamp and TOT into the out_* registers, set out_chan=sel and out_valid=1, go to PRESENT.
  - Latency: hasEvent high at edge N gives out_valid high after edge N+1.
- PRESENT:
  - Hold out_* stable while out_valid=1 and out_ready=0. Inputs are not resampled.
  - On out_valid & out_ready: out_valid<=0, chan_clear[sel]<=1 (one cycle), rr_ptr<=(sel+1) mod NUM_CHAN, event_count<=event_count+1 saturating at 2^CNT_W-1, go to CLEAR.
- CLEAR:
  - chan_clear[sel] high for exactly this one cycle.
  - Next edge: chan_clear<=0, go to IDLE.
  - The channel's hasEvent is not sampled for arbitration until IDLE, which avoids re-granting a stale flag.
- Throughput: one event per 3 cycles with out_ready held high.
- enable deasserted in PRESENT or CLEAR: the current transaction completes normally. Only new grants from IDLE are blocked.
- Several channels pending simultaneously: strict round-robin. A channel that was just served has lowest priority next time.
- Channel hasEvent drops while in PRESENT: no effect, because the latched data stays valid and is still delivered.
- flush (any state, lower priority than reset):
  - out_valid<=0 with the held event discarded (event_count unchanged).
  - chan_clear<=all ones for one cycle, state<=CLEAR, rr_ptr unchanged.
- out_ready high while out_valid=0: ignored.
- Reset mid-operation: immediate return to reset values at that edge. Any held event is lost.

Test Plan:
- Single event: after reset, ch2 hasEvent=1, ts=25505, tot=199099, out_ready=1 → out_valid 1 cycle later with out_chan=2, out_timestamp=25505, out_tot=199099; chan_clear=4'b0100 on the following cycle; event_count=1.
- Round-robin: ch0..ch3 all pending; each TDC model drops hasEvent on clear and re-raises it 1 cycle later → grant order 0,1,2,3,0,1; a grant every 3 cycles; event_count=6 after 18 cycles.
- Backpressure: ch1 event ts=100; out_ready held 0 for 10 cycles while ch1 inputs change to ts=555 → out_* stay at ts=100 and out_valid stays high; no chan_clear; clear pulses the cycle after ready rises.
- enable/flush: enable=0 with ch3 pending → no grant, busy=0. In PRESENT, pulse flush → out_valid=0 next cycle, chan_clear=4'b1111 for one cycle, event_count unchanged.
- Reset: reset_n low for 2 cycles mid-PRESENT → out_valid=0, chan_clear=4'b1111 during reset, 0 the cycle after release, rr_ptr=0 (ch0 wins over ch1 when both pending).
- Saturation: CNT_W=4, 20 accepted events → event_count holds at 15.
